cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, CPU word and address width.
REQ-002 SHALL have parameter FETCH_SIZE, default 64, memory line width (4 words).
REQ-003 SHALL have clk  input  1  rising-edge clock.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have cpu_read  input  1  read request, held until cpu_ready.
REQ-006 SHALL have cpu_write  input  1  write request, held until cpu_ready.
REQ-007 SHALL have cpu_address  input  16  word address.
REQ-008 SHALL have cpu_wdata  input  16  write data.
REQ-009 SHALL have cpu_rdata  output  16  read data, valid while cpu_ready is high.
REQ-010 SHALL have cpu_ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have readM  output  1  memory line-fetch request.
REQ-012 SHALL have writeM  output  1  memory line-store request.
REQ-013 SHALL have addressM  output  16  line-aligned memory address, with bits [1:0] = 0.
REQ-014 SHALL have dataM  inout  64  memory line bus; word k occupies bits [16k+15:16k].

Function
REQ-015 SHALL implement a direct-mapped, write-back, write-allocate cache of 4 lines x 4 words: tag = addr[15:4], index = addr[3:2], offset = addr[1:0]; each line has valid and dirty bits.
REQ-016 SHALL use FSM states IDLE, COMPARE, WRITEBACK and ALLOCATE.
REQ-017 IDLE: if cpu_read or cpu_write is high, SHALL latch address, wdata and type, then go to COMPARE; read has priority when both are high.
REQ-018 COMPARE on a hit (valid and tag match) SHALL pulse cpu_ready for one cycle, then return to IDLE.
  - Read hit: cpu_rdata = selected word.
  - Write hit: update the word at the clock edge and set dirty.
REQ-019 COMPARE on a miss SHALL go to WRITEBACK if the line is valid and dirty, otherwise to ALLOCATE.
REQ-020 WRITEBACK: SHALL hold writeM=1, addressM={old tag, index, 00} and drive the line on dataM for exactly 5 cycles (C0..C4); SHALL release writeM and dataM in C5 and enter ALLOCATE.
REQ-021 ALLOCATE: SHALL hold readM=1 and addressM={new tag, index, 00} for C0..C4 and capture dataM at the edge ending C4; SHALL set valid=1, dirty=0 and tag, deassert readM in C5, and return to COMPARE (guaranteed hit).
REQ-022 dataM SHALL be high-impedance in every state except WRITEBACK; readM and writeM SHALL never be high together.
REQ-023 Latency from the first request cycle to cpu_ready SHALL be:
  - hit: 2 cycles
  - clean miss: 8 cycles
  - dirty miss: 13 cycles
REQ-024 cpu_ready SHALL be 0 in every state except COMPARE-hit; cpu_rdata SHALL be 0 when cpu_ready is 0.

Reset
REQ-025 reset SHALL asynchronously force:
  - state = IDLE
  - all valid and dirty bits = 0
  - readM, writeM, cpu_ready = 0
  - addressM, cpu_rdata = 0
  - dataM = high-impedance
REQ-026 On reset mid-WRITEBACK or mid-ALLOCATE, the in-flight transfer SHALL be abandoned without updating any line.

Configuration
REQ-027 With macro CACHE_STATS_EN defined, the block SHALL add outputs hit_count and miss_count (16 bits each, reset to 0, wrap on overflow).
  - Each request increments exactly one counter.
  - A request that completes with no memory traffic counts as a hit; any other request counts as a miss.
REQ-028 Without CACHE_STATS_EN, these ports and counters SHALL be absent and the behaviour SHALL otherwise be identical.

Verification
All scenarios use a 4-cycle memory model preloaded with mem[0]=0x9023, mem[1]=0x0001, mem[2]=0xFFFF, mem[3]=0x0000, mem[0x10..0x13]=0x1111.
REQ-029 After reset, read 0x0001 -> readM=1 with addressM=0x0000 for 5 cycles; cpu_ready in cycle 8 with cpu_rdata=0x0001.
REQ-030 Next, read 0x0002 -> no memory traffic; cpu_ready in cycle 2 with cpu_rdata=0xFFFF.
REQ-031 Write 0x0003=0xABCD (hit), then read 0x0010 -> writeM at 0x0000 with dataM=0xABCD_FFFF_0001_9023, then readM at 0x0010; cpu_rdata=0x1111 in cycle 13.
REQ-032 Write miss 0x0025=0x5A5A on a clean line -> allocate 0x0024, word updated, dirty set; a following read of 0x0025 hits and returns 0x5A5A.
REQ-033 Assert reset during ALLOCATE C2 -> readM=0 and dataM high-impedance in the same cycle; a following read of 0x0001 misses again.
REQ-034 With CACHE_STATS_EN, after the REQ-029 and REQ-030 sequence -> hit_count=1, miss_count=1.

Source files
------------

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//   Direct-mapped, write-back, write-allocate cache: 4 lines x 4 words.
//   Address split: tag = addr[15:4], index = addr[3:2], offset = addr[1:0].
//   A miss on a dirty line stores the old line first (WRITEBACK, 5 cycles).
//   The new line is then fetched (ALLOCATE, 5 cycles). The request is then
//   re-evaluated in COMPARE, where it is guaranteed to hit.
//
//   Optional feature: define CACHE_STATS_EN to add hit_count / miss_count.
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int WORD_SIZE  = 16,
    parameter int FETCH_SIZE = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [WORD_SIZE-1:0]  cpu_address,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    output logic                  cpu_ready,
    output logic                  readM,
    output logic                  writeM,
    output logic [WORD_SIZE-1:0]  addressM,
    inout  wire  [FETCH_SIZE-1:0] dataM
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int OFF_W      = 2;
    localparam int IDX_W      = 2;
    localparam int LINES      = 1 << IDX_W;
    localparam int TAG_W      = WORD_SIZE - OFF_W - IDX_W;
    localparam int BURST_LAST = 4;     // memory transfers last C0..C4

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_cnt;

    // Latched request
    logic [WORD_SIZE-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic                   r_is_write;

    // Line storage and per-line status
    logic [LINES-1:0]       r_valid;
    logic [LINES-1:0]       r_dirty;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [FETCH_SIZE-1:0]  r_line [LINES];

    logic [TAG_W-1:0]       w_tag;
    logic [IDX_W-1:0]       w_idx;
    logic [OFF_W-1:0]       w_off;
    logic                   w_hit;
    logic                   w_burst_done;
    logic                   w_capture;
    logic                   w_write_hit;
    logic                   w_drive;
    logic [WORD_SIZE-1:0]   w_word;

    assign w_tag        = r_addr[WORD_SIZE-1 -: TAG_W];
    assign w_idx        = r_addr[OFF_W +: IDX_W];
    assign w_off        = r_addr[OFF_W-1:0];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_burst_done = (r_cnt == 3'(BURST_LAST));
    assign w_word       = r_line[w_idx][w_off*WORD_SIZE +: WORD_SIZE];

    // A line is captured at the edge that ends ALLOCATE C4
    assign w_capture    = (r_state == ALLOCATE) && w_burst_done;
    assign w_write_hit  = (r_state == COMPARE) && w_hit && r_is_write;

    // Line bus is driven only while storing a dirty line
    assign dataM = w_drive ? r_line[w_idx] : {FETCH_SIZE{1'bz}};

    // State register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst cycle counter: restarts on every state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == WRITEBACK || r_state == ALLOCATE) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    // Latch the CPU request in IDLE; read wins when both are raised
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
        end else if (r_state == IDLE && (cpu_read || cpu_write)) begin
            r_addr     <= cpu_address;
            r_wdata    <= cpu_wdata;
            r_is_write <= !cpu_read;
        end
    end

    // Valid/dirty bits: set on line fill, dirty on write hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_capture) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
        end else if (w_write_hit) begin
            r_dirty[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage: line fill from dataM, word update on write hit
    // NOTE: the tag/data arrays are deliberately not reset; the valid bits
    // gate every use, and leaving them unreset allows a RAM implementation.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_tag[w_idx]  <= w_tag;
            r_line[w_idx] <= dataM;
        end else if (w_write_hit) begin
            r_line[w_idx][w_off*WORD_SIZE +: WORD_SIZE] <= r_wdata;
        end
    end

    // Next-state and output decode
    // NOTE: every signal gets a default before the case; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        readM        = 1'b0;
        writeM       = 1'b0;
        addressM     = '0;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        w_drive      = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_read || cpu_write) begin
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (w_hit) begin
                    cpu_ready    = 1'b1;
                    cpu_rdata    = r_is_write ? '0 : w_word;
                    w_state_next = IDLE;
                end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                    w_state_next = WRITEBACK;
                end else begin
                    w_state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                writeM   = 1'b1;
                w_drive  = 1'b1;
                addressM = {r_tag[w_idx], w_idx, {OFF_W{1'b0}}};
                if (w_burst_done) begin
                    w_state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                readM    = 1'b1;
                addressM = {w_tag, w_idx, {OFF_W{1'b0}}};
                if (w_burst_done) begin
                    w_state_next = COMPARE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic r_missed;     // current request has already missed once

    // Hit/miss statistics: one increment per request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            r_missed   <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_missed <= 1'b0;
            end
            if (r_state == COMPARE) begin
                if (!w_hit) begin
                    miss_count <= miss_count + 16'd1;
                    r_missed   <= 1'b1;
                end else if (!r_missed) begin
                    hit_count  <= hit_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//   Table-driven bench for cache_controller with a 4-cycle line memory.
//   Build with +define+CACHE_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    logic        clk;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        readM;
    logic        writeM;
    logic [15:0] addressM;
    wire  [63:0] dataM;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cache_controller #(.WORD_SIZE(16), .FETCH_SIZE(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .readM       (readM),
        .writeM      (writeM),
        .addressM    (addressM),
        .dataM       (dataM)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mem [0:255];
    int          mem_rd_cnt = 0;
    int          mem_wr_cnt = 0;
    logic [7:0]  mem_a;
    logic [63:0] mem_line;

    assign mem_a    = addressM[7:0];
    assign mem_line = {mem[mem_a + 8'd3], mem[mem_a + 8'd2], mem[mem_a + 8'd1], mem[mem_a]};
    // Data appears after the line request has been held for 3 cycles
    assign dataM    = (readM && mem_rd_cnt >= 3) ? mem_line : 64'bz;

    // Memory burst counters; a line store commits at the end of C4
    always @(posedge clk) begin
        mem_rd_cnt <= readM ? mem_rd_cnt + 1 : 0;
        mem_wr_cnt <= writeM ? mem_wr_cnt + 1 : 0;
        if (writeM && mem_wr_cnt == 4) begin
            mem[mem_a]        <= dataM[15:0];
            mem[mem_a + 8'd1] <= dataM[31:16];
            mem[mem_a + 8'd2] <= dataM[47:32];
            mem[mem_a + 8'd3] <= dataM[63:48];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    int          mon_rd = 0;
    int          mon_wr = 0;
    logic [15:0] mon_rd_addr;
    logic [15:0] mon_wr_addr;
    logic [63:0] mon_wr_data;

    // Per-cycle protocol checks and traffic recording
    always @(negedge clk) begin
        if (!reset) begin
            check("rw_exclusive", 64'(readM & writeM), 64'd0);
            if (!cpu_ready) check("rdata_zero_idle", 64'(cpu_rdata), 64'd0);
            if (!writeM && !(readM && mem_rd_cnt >= 3))
                check("dataM_hiz", 64'(dataM === 64'bz), 64'd1);
            if (readM || writeM) check("addrM_aligned", 64'(addressM[1:0]), 64'd0);
            if (readM) begin
                mon_rd++;
                mon_rd_addr = addressM;
            end
            if (writeM) begin
                mon_wr++;
                mon_wr_addr = addressM;
                mon_wr_data = dataM;
            end
        end
    end

    // One CPU request; latency counted from the first request cycle (= 1)
    task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output int lat, output logic [15:0] rdata);
        logic got;
        @(negedge clk);
        mon_rd      = 0;
        mon_wr      = 0;
        cpu_read    = !wr;
        cpu_write   = wr;
        cpu_address = addr;
        cpu_wdata   = wdata;
        lat   = 1;
        got   = 1'b0;
        rdata = '0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (cpu_ready) begin
                got   = 1'b1;
                rdata = cpu_rdata;
            end
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        if (!got) check("ready_timeout", 64'd0, 64'd1);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_lat;
        logic        exp_wb;
        logic [15:0] exp_wb_addr;
        logic [63:0] exp_wb_data;
        logic [15:0] exp_rd_addr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int          lat;
        int          n;
        logic [15:0] rdata;
        int          exp_hits;
        int          exp_misses;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0] = 16'h9023; mem[1] = 16'h0001; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
        for (int i = 16; i < 20; i++) mem[i] = 16'h1111;

        //           wr    addr      wdata     rdata     lat wb    wb_addr   wb_data                 rd_addr
        vecs[0]  = '{1'b0, 16'h0001, 16'h0000, 16'h0001, 8,  1'b0, 16'h0000, 64'h0,                  16'h0000};
        vecs[1]  = '{1'b0, 16'h0002, 16'h0000, 16'hFFFF, 2,  1'b0, 16'h0000, 64'h0,                  16'h0000};
        vecs[2]  = '{1'b1, 16'h0003, 16'hABCD, 16'h0000, 2,  1'b0, 16'h0000, 64'h0,                  16'h0000};
        vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 16'h1111, 13, 1'b1, 16'h0000, 64'hABCD_FFFF_0001_9023, 16'h0010};
        vecs[4]  = '{1'b1, 16'h0025, 16'h5A5A, 16'h0000, 8,  1'b0, 16'h0000, 64'h0,                  16'h0024};
        vecs[5]  = '{1'b0, 16'h0025, 16'h0000, 16'h5A5A, 2,  1'b0, 16'h0000, 64'h0,                  16'h0000};
        vecs[6]  = '{1'b0, 16'h0003, 16'h0000, 16'hABCD, 8,  1'b0, 16'h0000, 64'h0,                  16'h0000};
        vecs[7]  = '{1'b0, 16'h0024, 16'h0000, 16'h0000, 2,  1'b0, 16'h0000, 64'h0,                  16'h0000};
        vecs[8]  = '{1'b0, 16'h0011, 16'h0000, 16'h1111, 8,  1'b0, 16'h0000, 64'h0,                  16'h0010};
        vecs[9]  = '{1'b0, 16'h0035, 16'h0000, 16'h0000, 13, 1'b1, 16'h0024, 64'h0000_0000_5A5A_0000, 16'h0034};
        vecs[10] = '{1'b0, 16'h0025, 16'h0000, 16'h5A5A, 8,  1'b0, 16'h0000, 64'h0,                  16'h0024};

        reset       = 1'b1;
        cpu_read    = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        repeat (3) @(negedge clk);

        check("reset_readM",     64'(readM),          64'd0);
        check("reset_writeM",    64'(writeM),         64'd0);
        check("reset_ready",     64'(cpu_ready),      64'd0);
        check("reset_addressM",  64'(addressM),       64'd0);
        check("reset_rdata",     64'(cpu_rdata),      64'd0);
        check("reset_dataM_hiz", 64'(dataM === 64'bz), 64'd1);
`ifdef CACHE_STATS_EN
        check("reset_hits",   64'(hit_count),  64'd0);
        check("reset_misses", 64'(miss_count), 64'd0);
`endif
        reset = 1'b0;

        exp_hits   = 0;
        exp_misses = 0;
        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdata);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            if (!vecs[i].wr) check($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
            check($sformatf("v%0d_fetch_cycles", i), 64'(mon_rd), (vecs[i].exp_lat > 2) ? 64'd5 : 64'd0);
            if (vecs[i].exp_lat > 2)
                check($sformatf("v%0d_fetch_addr", i), 64'(mon_rd_addr), 64'(vecs[i].exp_rd_addr));
            check($sformatf("v%0d_store_cycles", i), 64'(mon_wr), vecs[i].exp_wb ? 64'd5 : 64'd0);
            if (vecs[i].exp_wb) begin
                check($sformatf("v%0d_store_addr", i), 64'(mon_wr_addr), 64'(vecs[i].exp_wb_addr));
                check($sformatf("v%0d_store_data", i), mon_wr_data, vecs[i].exp_wb_data);
            end
            if (vecs[i].exp_lat == 2) exp_hits++;
            else                      exp_misses++;
`ifdef CACHE_STATS_EN
            @(negedge clk);
            check($sformatf("v%0d_hits", i),   64'(hit_count),  64'(exp_hits));
            check($sformatf("v%0d_misses", i), 64'(miss_count), 64'(exp_misses));
`endif
        end

        // Reset in ALLOCATE C2: transfer abandoned in the same cycle
        @(negedge clk);
        cpu_read    = 1'b1;
        cpu_address = 16'h0031;
        n = 0;
        while (!readM && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("alloc_started", 64'(readM), 64'd1);
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        cpu_read = 1'b0;
        #1;
        check("rst_alloc_readM",    64'(readM),           64'd0);
        check("rst_alloc_dataM",    64'(dataM === 64'bz), 64'd1);
        check("rst_alloc_addressM", 64'(addressM),        64'd0);
        check("rst_alloc_ready",    64'(cpu_ready),       64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // All lines were invalidated: 0x0001 misses again
        do_req(1'b0, 16'h0001, 16'h0000, lat, rdata);
        check("post_rst_latency",      64'(lat),         64'd8);
        check("post_rst_rdata",        64'(rdata),       64'h0001);
        check("post_rst_fetch_cycles", 64'(mon_rd),      64'd5);
        check("post_rst_fetch_addr",   64'(mon_rd_addr), 64'h0000);
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("post_rst_hits",   64'(hit_count),  64'd0);
        check("post_rst_misses", 64'(miss_count), 64'd1);
`endif

        // Both requests raised: read wins
        do_req(1'b0, 16'h0002, 16'h0000, lat, rdata);
        check("hit_after_refill", 64'(rdata), 64'hFFFF);
        @(negedge clk);
        cpu_read    = 1'b1;
        cpu_write   = 1'b1;
        cpu_address = 16'h0001;
        cpu_wdata   = 16'hDEAD;
        n = 0;
        while (!cpu_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("both_req_rdata", 64'(cpu_rdata), 64'h0001);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        do_req(1'b0, 16'h0001, 16'h0000, lat, rdata);
        check("both_req_no_write", 64'(rdata), 64'h0001);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
